keypad_col_decoder: RTL and testbench
=====================================

Name: keypad_col_decoder

Overview:
Receive side of the 4x4 matrix keypad interface. The row scanner drives one-hot rows; this block samples the four column lines and synchronizes and debounces them. It produces a 4-bit key code with a single-cycle valid strobe. It asserts hold_scan to freeze the row scanner on the active row while a key is being qualified, held or released.

Parameters:
DEB_CYCLES, 16, consecutive clk cycles a column level must be stable to accept a press or release. Legal range is at least 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  reset, synchronous, active-high
scan_tick  input  1  one-cycle pulse at the last clk cycle of each row slot; row and col are settled here
row  input  4  one-hot row currently driven by the row scanner
col  input  4  raw asynchronous column lines, active-high
hold_scan  output  1  high freezes the scanner on the current row
key_code  output  4  {row_idx[1:0], col_idx[1:0]}, i.e. row_idx*4 + col_idx
key_valid  output  1  one-cycle strobe when a debounced press is accepted
key_down  output  1  high from press acceptance until release acceptance

Behaviour:
- Reset values:
  - State SCAN; hold_scan=0, key_code=0, key_valid=0, key_down=0.
  - Debounce counter=0; captured indices=0; synchronizer flops=0.
- col passes through a 2-flop synchronizer. col_sync lags col by 2 cycles. All decisions use col_sync only.
- The counter is $clog2(DEB_CYCLES+1) bits wide. It saturates and never wraps.
- All outputs are registered. key_code holds its last value until the next key_valid.
- State SCAN:
  - hold_scan=0. Act only on cycles with scan_tick=1.
  - If row is one-hot and col_sync != 0:
    - Capture row_idx: 0001->0, 0010->1, 0100->2, 1000->3.
    - Capture col_idx as the lowest-index set bit of col_sync.
    - Clear the counter, go to DEBOUNCE, and set hold_scan=1 in the next cycle.
  - If row is not one-hot (0000, 0011, etc.), ignore the tick.
- State DEBOUNCE:
  - hold_scan=1. Track captured bit b = col_sync[col_idx].
  - If b=1 and counter == DEB_CYCLES-1: go to PRESSED. key_code={row_idx,col_idx}, key_valid=1 and key_down=1 in the next cycle.
  - Else if b=1: increment the counter.
  - If b=0: return to SCAN, clear the counter, set hold_scan=0 next cycle, and emit no key_valid.
- Press latency: with scan_tick capture in cycle T, key_valid is high in cycle T+DEB_CYCLES+1 for exactly one cycle.
- State PRESSED:
  - hold_scan=1, key_down=1, key_valid=0 after its first cycle.
  - If b=0: clear the counter and go to RELEASE.
- State RELEASE:
  - hold_scan=1, key_down=1.
  - If b=0 and counter == DEB_CYCLES-1: go to SCAN. hold_scan=0 and key_down=0 in the next cycle.
  - Else if b=0: increment the counter.
  - If b=1 (bounce): clear the counter and return to PRESSED with no new key_valid.
- scan_tick and row are ignored outside SCAN.
- Other columns changing while in DEBOUNCE, PRESSED or RELEASE are ignored. There is no rollover and no second key.
- Release uses the same DEB_CYCLES window as press. Next press detection requires a fresh scan_tick in SCAN.
- rst asserted in any state: all state and outputs return to reset values on the next edge; a pending key_valid is dropped.

Test Plan:
All scenarios use DEB_CYCLES=4.
1. Stable press: row=0100, col=0010 held from 3 cycles before scan_tick at T -> hold_scan=1 at T+1; key_code=4'h9, key_valid=1 only at T+5; key_down=1 from T+5.
2. Bounce press: same setup, col drops to 0000 after 2 cycles in DEBOUNCE -> no key_valid, key_code unchanged, hold_scan=0, state SCAN.
3. Release with glitch, from scenario 1: col_sync bit low 2 cycles, high 1 cycle, then low -> key_down stays 1 through the glitch; key_down=0 and hold_scan=0 exactly 5 cycles after the final fall reaches col_sync.
4. Multi-column: row=0001, col=0110 at scan_tick -> key_code=4'h1 after debounce, single key_valid.
5. Invalid row: row=0011 or 0000 with col=1000 at scan_tick -> no state change, hold_scan=0, no key_valid.
6. Reset mid-operation: rst=1 for 1 cycle during DEBOUNCE and again during PRESSED -> next cycle all outputs 0, key_code=0; a held key is re-detected only after a new scan_tick and a full debounce.

Source files
------------

// File: rtl/keypad_col_decoder.sv
// Column-side receiver for a 4x4 matrix keypad. Synchronizes the raw column
// lines, qualifies one key at a time with a debounce window on both press and
// release, and freezes the row scanner while a key is being handled.
module keypad_col_decoder #(
  parameter int unsigned DEB_CYCLES = 16  // must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       hold_scan,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_meta_q, col_sync_q;
  logic            hold_q, hold_d;
  logic            valid_q, valid_d;
  logic            down_q, down_d;
  logic [3:0]      code_q, code_d;

  logic            row_ok;
  logic [1:0]      row_dec;
  logic [1:0]      col_dec;
  logic            col_bit;

  // Two-flop synchronizer on the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'b0000;
      col_sync_q <= 4'b0000;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // One-hot row to index; anything else is not a valid scan slot.
  always_comb begin
    row_ok  = 1'b1;
    row_dec = 2'd0;
    case (row)
      4'b0001: row_dec = 2'd0;
      4'b0010: row_dec = 2'd1;
      4'b0100: row_dec = 2'd2;
      4'b1000: row_dec = 2'd3;
      default: row_ok  = 1'b0;
    endcase
  end

  // Lowest-index active column wins when several are high.
  always_comb begin
    col_dec = 2'd3;
    if (col_sync_q[0])      col_dec = 2'd0;
    else if (col_sync_q[1]) col_dec = 2'd1;
    else if (col_sync_q[2]) col_dec = 2'd2;
  end

  assign col_bit = col_sync_q[col_idx_q];
  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);

  // Next-state logic for the key qualification FSM and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    valid_d   = 1'b0;

    case (state_q)
      StScan: begin
        if (scan_tick && row_ok && (col_sync_q != 4'b0000)) begin
          row_idx_d = row_dec;
          col_idx_d = col_dec;
          cnt_d     = '0;
          state_d   = StDebounce;
        end
      end
      StDebounce: begin
        if (col_bit) begin
          if (cnt_q == CntLast) begin
            state_d = StPressed;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StPressed: begin
        if (!col_bit) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!col_bit) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StScan;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Bounce during release: back to held, no new strobe.
          cnt_d   = '0;
          state_d = StPressed;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StScan;
      end
    endcase

    hold_d = (state_d != StScan);
    down_d = (state_d == StPressed) || (state_d == StRelease);
    code_d = valid_d ? {row_idx_d, col_idx_d} : code_q;
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StScan;
      cnt_q     <= '0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      hold_q    <= 1'b0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
      code_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
      code_q    <= code_d;
    end
  end

  assign hold_scan = hold_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_col_decoder.sv
// Directed bench for keypad_col_decoder with DEB_CYCLES=4. Expected key codes
// are queued when a qualifying press is driven and matched on each key_valid.
module tb_keypad_col_decoder;

  logic       clk;
  logic       rst;
  logic       scan_tick;
  logic [3:0] row;
  logic [3:0] col;
  logic       hold_scan;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;

  keypad_col_decoder #(
    .DEB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_tick(scan_tick),
    .row      (row),
    .col      (col),
    .hold_scan(hold_scan),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic hold, input logic valid,
                          input logic down);
    chk({tag, "_hold"}, {3'b0, hold_scan}, {3'b0, hold});
    chk({tag, "_valid"}, {3'b0, key_valid}, {3'b0, valid});
    chk({tag, "_down"}, {3'b0, key_down}, {3'b0, down});
  endtask

  // Scoreboard: every key_valid must consume one queued expected code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_valid observed=%h expected=none", key_code);
      end
      if (exp_q.size() > 0) begin
        exp_code = exp_q.pop_front();
        checks++;
        assert (key_code === exp_code) else begin
          failures++;
          $error("FAIL sb_key_code observed=%h expected=%h", key_code, exp_code);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    scan_tick = 1'b0;
    row       = 4'b0000;
    col       = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_code", key_code, 4'h0);

    // 1. Stable press on row 2 / col 1: key 9.
    row = 4'b0100;
    col = 4'b0010;
    repeat (3) tick();
    scan_tick = 1'b1;
    exp_q.push_back(4'h9);
    tick();                                   // T+1
    scan_tick = 1'b0;
    chk_outs("s1_t1", 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_outs("s1_deb", 1'b1, 1'b0, 1'b0);
    end
    tick();                                   // T+5
    chk_outs("s1_t5", 1'b1, 1'b1, 1'b1);
    chk("s1_code", key_code, 4'h9);
    tick();                                   // T+6
    chk_outs("s1_t6", 1'b1, 1'b0, 1'b1);

    // 3. Release with a one-cycle glitch; final fall reaches col_sync at R+5.
    col = 4'b0000;                            // R
    tick();
    chk_outs("s3_r1", 1'b1, 1'b0, 1'b1);
    tick();
    col = 4'b0010;                            // R+2
    chk_outs("s3_r2", 1'b1, 1'b0, 1'b1);
    tick();
    col = 4'b0000;                            // R+3
    chk_outs("s3_r3", 1'b1, 1'b0, 1'b1);
    for (int i = 4; i <= 9; i++) begin
      tick();
      chk_outs("s3_hold", 1'b1, 1'b0, 1'b1);
    end
    tick();                                   // R+10
    chk_outs("s3_done", 1'b0, 1'b0, 1'b0);
    chk("s3_code_kept", key_code, 4'h9);

    // 2. Bounce during debounce: no strobe, back to scanning.
    col = 4'b0010;
    repeat (3) tick();
    scan_tick = 1'b1;
    tick();                                   // T+1
    scan_tick = 1'b0;
    col = 4'b0000;
    chk_outs("s2_t1", 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      chk_outs("s2_deb", 1'b1, 1'b0, 1'b0);
    end
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk_outs("s2_scan", 1'b0, 1'b0, 1'b0);
    end
    chk("s2_code", key_code, 4'h9);

    // 4. Multiple columns on row 0: lowest column wins, key 1.
    row = 4'b0001;
    col = 4'b0110;
    repeat (3) tick();
    scan_tick = 1'b1;
    exp_q.push_back(4'h1);
    tick();
    scan_tick = 1'b0;
    repeat (3) tick();
    tick();                                   // T+5
    chk_outs("s4_t5", 1'b1, 1'b1, 1'b1);
    chk("s4_code", key_code, 4'h1);
    col = 4'b0000;
    repeat (10) tick();
    chk_outs("s4_rel", 1'b0, 1'b0, 1'b0);

    // 5. Invalid rows are ignored.
    row = 4'b0011;
    col = 4'b1000;
    repeat (3) tick();
    scan_tick = 1'b1;
    tick();
    chk_outs("s5_row3", 1'b0, 1'b0, 1'b0);
    row = 4'b0000;
    tick();
    scan_tick = 1'b0;
    chk_outs("s5_row0", 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    chk_outs("s5_after", 1'b0, 1'b0, 1'b0);
    chk("s5_code", key_code, 4'h1);
    col = 4'b0000;
    repeat (3) tick();

    // 6a. Reset during debounce drops the pending strobe.
    row = 4'b0100;
    col = 4'b0010;
    repeat (3) tick();
    scan_tick = 1'b1;
    tick();                                   // T+1
    scan_tick = 1'b0;
    chk_outs("s6_deb", 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("s6_rst1", 1'b0, 1'b0, 1'b0);
    chk("s6_rst1_code", key_code, 4'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_outs("s6_idle1", 1'b0, 1'b0, 1'b0);
    end

    // Held key re-detected only after a fresh tick and full debounce.
    scan_tick = 1'b1;
    exp_q.push_back(4'h9);
    tick();
    scan_tick = 1'b0;
    repeat (3) tick();
    chk_outs("s6_t4", 1'b1, 1'b0, 1'b0);
    tick();                                   // T+5
    chk_outs("s6_t5", 1'b1, 1'b1, 1'b1);
    tick();

    // 6b. Reset while pressed.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("s6_rst2", 1'b0, 1'b0, 1'b0);
    chk("s6_rst2_code", key_code, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_outs("s6_idle2", 1'b0, 1'b0, 1'b0);
    end
    scan_tick = 1'b1;
    exp_q.push_back(4'h9);
    tick();
    scan_tick = 1'b0;
    repeat (4) tick();
    chk_outs("s6_redet", 1'b1, 1'b1, 1'b1);
    chk("s6_redet_code", key_code, 4'h9);
    col = 4'b0000;
    repeat (10) tick();
    chk_outs("s6_rel", 1'b0, 1'b0, 1'b0);

    tick();
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_missing_valid observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
